// File: rtl/mem_responder_pkg.sv
// Shared types for mem_responder: FSM state, port identifiers and the latched request.
package mem_resp_types;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_resp_state_t;

    typedef enum logic {
        PORT_INSTR,
        PORT_DATA
    } mem_port_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        is_write;
        mem_port_t   port;
    } mem_req_t;

endpackage

// File: rtl/mem_responder_byte_en_ram.sv
// byte_en_ram: single-port DEPTH_WORDS x 32 array, read-first, byte-lane writes.
// Latency 1 cycle (rdata registered on an enabled edge); no backpressure, one access per cycle.
module byte_en_ram #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Read-first: rdata returns the word as it was before this edge's write.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (we && be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: arbitrated instr/data responder over one byte-writable RAM; MEM_RESP_RR_ARB_EN enables round-robin arbitration.
// LATENCY cycles grant->resp, one access per LATENCY+1 cycles; requesters hold their request until resp.
module mem_responder
    import mem_resp_types::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_mem_read,
    input  logic [31:0] instr_mem_address,
    output logic [31:0] instr_mem_rdata,
    output logic        instr_mem_resp,
    input  logic        data_mem_read,
    input  logic        data_mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] data_mem_address,
    input  logic [31:0] data_mem_wdata,
    output logic [31:0] data_mem_rdata,
    output logic        data_mem_resp
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    mem_resp_state_t state;
    logic [CW-1:0]   cnt;
    mem_req_t        req_q;
    mem_req_t        live_req;
    mem_req_t        cur_req;
    mem_port_t       grant_port;
    logic            data_req;
    logic            instr_req;
    logic            any_req;
    logic            enter_resp;
    logic            instr_resp_q;
    logic            data_resp_q;
    logic [31:0]     instr_rdata_q;
    logic [31:0]     data_rdata_q;
    logic [31:0]     ram_rdata;
    logic            unused_addr_bits;
`ifdef MEM_RESP_RR_ARB_EN
    mem_port_t       rr_last;
`endif

    always_comb begin
        data_req  = data_mem_read | data_mem_write;
        instr_req = instr_mem_read;
        any_req   = data_req | instr_req;
`ifdef MEM_RESP_RR_ARB_EN
        if (data_req && instr_req) begin
            grant_port = (rr_last == PORT_DATA) ? PORT_INSTR : PORT_DATA;
        end else begin
            grant_port = data_req ? PORT_DATA : PORT_INSTR;
        end
`else
        grant_port = data_req ? PORT_DATA : PORT_INSTR;
`endif
        live_req      = '0;
        live_req.port = grant_port;
        if (grant_port == PORT_DATA) begin
            live_req.addr     = data_mem_address;
            live_req.wdata    = data_mem_wdata;
            live_req.be       = mem_byte_enable;
            live_req.is_write = data_mem_write;
        end else begin
            live_req.addr = instr_mem_address;
        end
        // With LATENCY==1 the RAM access happens on the grant edge, before req_q holds it.
        cur_req    = (state == IDLE) ? live_req : req_q;
        enter_resp = ((state == IDLE) && any_req && (LATENCY == 1)) ||
                     ((state == BUSY) && (cnt == '0));
    end

    assign unused_addr_bits = ^{cur_req.addr[31:AW+2], cur_req.addr[1:0]};

    byte_en_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .en    (enter_resp & rst),
        .we    (cur_req.is_write),
        .be    (cur_req.be),
        .addr  (cur_req.addr[AW+1:2]),
        .wdata (cur_req.wdata),
        .rdata (ram_rdata)
    );

    // The RAM output register is the port's rdata during its resp cycle; it is then copied to hold.
    assign instr_mem_resp  = instr_resp_q;
    assign data_mem_resp   = data_resp_q;
    assign instr_mem_rdata = instr_resp_q ? ram_rdata : instr_rdata_q;
    assign data_mem_rdata  = data_resp_q  ? ram_rdata : data_rdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            req_q         <= '0;
            instr_resp_q  <= 1'b0;
            data_resp_q   <= 1'b0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
`ifdef MEM_RESP_RR_ARB_EN
            rr_last       <= PORT_INSTR;
`endif
        end else begin
            instr_resp_q <= enter_resp && (cur_req.port == PORT_INSTR);
            data_resp_q  <= enter_resp && (cur_req.port == PORT_DATA);
            if (instr_resp_q) begin
                instr_rdata_q <= ram_rdata;
            end
            if (data_resp_q) begin
                data_rdata_q <= ram_rdata;
            end
            case (state)
                IDLE: begin
                    if (any_req) begin
                        req_q <= live_req;
`ifdef MEM_RESP_RR_ARB_EN
                        rr_last <= grant_port;
`endif
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= BUSY;
                            cnt   <= CW'(LATENCY - 2);
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
